// File: rtl/hc_sign_linbits.sv
// hc_sign_linbits: reads linbits extensions and sign bits after a Huffman pair, then emits signed x,y
// in:  clk, rst, code_valid, code_x[3:0], code_y[3:0], linbits[3:0], bit_valid, bit_data
// out: bit_ready, busy, out_valid, x_out[OUT_W-1:0], y_out[OUT_W-1:0], err
module hc_sign_linbits #(
  parameter int LINBITS_MAX = 13,
  parameter int OUT_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [3:0]       code_x,
  input  logic [3:0]       code_y,
  input  logic [3:0]       linbits,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [OUT_W-1:0] x_out,
  output logic [OUT_W-1:0] y_out,
  output logic             err
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] X_LIN = 3'd1;
  localparam logic [2:0] X_SIGN = 3'd2;
  localparam logic [2:0] Y_LIN = 3'd3;
  localparam logic [2:0] Y_SIGN = 3'd4;
  logic [2:0] state;
  logic [3:0] cy, lb, cnt;
  logic [LINBITS_MAX-1:0] ext, ext_n;
  logic [OUT_W-1:0] xv, yv, xs, ys, mag_n;
  logic take;
  // a state is skipped when it has nothing to read; IDLE as a result means the pair is complete
  function automatic logic [2:0] nx_y(input logic [3:0] c, input logic [3:0] l);
    return (c == 4'd15 && l != 4'd0) ? Y_LIN : (c != 4'd0) ? Y_SIGN : IDLE;
  endfunction
  function automatic logic [2:0] nx_x(input logic [3:0] cx, input logic [3:0] c, input logic [3:0] l);
    return (cx == 4'd15 && l != 4'd0) ? X_LIN : (cx != 4'd0) ? X_SIGN : nx_y(c, l);
  endfunction
  assign bit_ready = state != IDLE;
  assign busy = state != IDLE;
  assign take = bit_valid && bit_ready;
  assign ext_n = {ext[LINBITS_MAX-2:0], bit_data};
  assign mag_n = OUT_W'(15) + OUT_W'(ext_n);
  assign xs = bit_data ? -xv : xv;
  assign ys = bit_data ? -yv : yv;
  always_ff @(posedge clk) begin
    out_valid <= 1'b0;
    err <= 1'b0;
    if (rst) begin
      state <= IDLE;
      x_out <= '0;
      y_out <= '0;
      cy <= '0;
      lb <= '0;
      cnt <= '0;
      ext <= '0;
      xv <= '0;
      yv <= '0;
    end else begin
      if (code_valid && (state != IDLE || linbits > 4'(LINBITS_MAX))) err <= 1'b1;
      case (state)
        IDLE: if (code_valid && linbits <= 4'(LINBITS_MAX)) begin
          cy <= code_y;
          lb <= linbits;
          cnt <= linbits;
          ext <= '0;
          xv <= OUT_W'(code_x);
          yv <= OUT_W'(code_y);
          state <= nx_x(code_x, code_y, linbits);
          if (nx_x(code_x, code_y, linbits) == IDLE) begin
            out_valid <= 1'b1;
            x_out <= '0;
            y_out <= '0;
          end
        end
        X_LIN: if (take) begin
          ext <= ext_n;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            xv <= mag_n;
            state <= X_SIGN;
          end
        end
        X_SIGN: if (take) begin
          xv <= xs;
          cnt <= lb;
          ext <= '0;
          state <= nx_y(cy, lb);
          if (nx_y(cy, lb) == IDLE) begin
            out_valid <= 1'b1;
            x_out <= xs;
            y_out <= yv;
          end
        end
        Y_LIN: if (take) begin
          ext <= ext_n;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            yv <= mag_n;
            state <= Y_SIGN;
          end
        end
        Y_SIGN: if (take) begin
          out_valid <= 1'b1;
          x_out <= xv;
          y_out <= ys;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hc_sign_linbits.sv
// tb_hc_sign_linbits: directed self-checking bench for hc_sign_linbits
module tb_hc_sign_linbits;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic code_valid = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_data = 1'b0;
  logic [3:0] code_x = '0;
  logic [3:0] code_y = '0;
  logic [3:0] linbits = '0;
  logic bit_ready, busy, out_valid, err;
  logic [14:0] x_out, y_out;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  hc_sign_linbits dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_x(code_x), .code_y(code_y),
    .linbits(linbits), .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .busy(busy), .out_valid(out_valid), .x_out(x_out), .y_out(y_out), .err(err)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic run_pair(input string tag, input logic [3:0] cx, input logic [3:0] cy,
                          input logic [3:0] lb, input logic [31:0] bits, input int nb,
                          input int ex, input int ey, input bit tog);
    int lat;
    int ptr;
    logic [14:0] exw, eyw;
    lat = 1;
    ptr = 0;
    exw = 15'(ex);
    eyw = 15'(ey);
    code_x = cx;
    code_y = cy;
    linbits = lb;
    code_valid = 1'b1;
    step;
    code_valid = 1'b0;
    while (!out_valid && lat < 200) begin
      bit_valid = !tog || (lat % 2 == 0);
      bit_data = (ptr < nb) ? bits[nb-1-ptr] : 1'b0;
      if (bit_valid && bit_ready) ptr++;
      if (tog && lat == 3) begin
        code_x = 4'd7;
        code_y = 4'd7;
        linbits = 4'd0;
        code_valid = 1'b1;
      end
      step;
      code_valid = 1'b0;
      if (tog && lat == 3) check({tag, " err_midpair"}, 32'(err), 32'd1);
      lat++;
    end
    bit_valid = 1'b0;
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(tog ? 2 * nb + 1 : nb + 1));
    check({tag, " bits_consumed"}, 32'(ptr), 32'(nb));
    check({tag, " x_out"}, 32'(x_out), 32'(exw));
    check({tag, " y_out"}, 32'(y_out), 32'(eyw));
    check({tag, " bit_ready_idle"}, 32'(bit_ready), 32'd0);
    step;
    check({tag, " pulse_end"}, 32'(out_valid), 32'd0);
    check({tag, " x_hold"}, 32'(x_out), 32'(exw));
  endtask
  initial begin
    step;
    step;
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset bit_ready", 32'(bit_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset x_out", 32'(x_out), 32'd0);
    check("reset y_out", 32'(y_out), 32'd0);
    run_pair("zero", 4'd0, 4'd0, 4'd0, 32'h0, 0, 0, 0, 1'b0);
    run_pair("x1neg", 4'd1, 4'd0, 4'd0, 32'h1, 1, -1, 0, 1'b0);
    run_pair("lin4", 4'd15, 4'd3, 4'd4, 32'b101001, 6, 25, -3, 1'b0);
    run_pair("lin13max", 4'd15, 4'd15, 4'd13, 32'h0FFFFFFF, 28, -8206, -8206, 1'b0);
    run_pair("x15lin0", 4'd15, 4'd0, 4'd0, 32'h1, 1, -15, 0, 1'b0);
    run_pair("x2y5", 4'd2, 4'd5, 4'd0, 32'b01, 2, 2, -5, 1'b0);
    run_pair("x2y5_tog", 4'd2, 4'd5, 4'd0, 32'b01, 2, 2, -5, 1'b1);
    code_x = 4'd15;
    code_y = 4'd15;
    linbits = 4'd14;
    code_valid = 1'b1;
    step;
    code_valid = 1'b0;
    check("badlin err", 32'(err), 32'd1);
    check("badlin busy", 32'(busy), 32'd0);
    step;
    check("badlin err_pulse", 32'(err), 32'd0);
    code_x = 4'd15;
    code_y = 4'd15;
    linbits = 4'd2;
    code_valid = 1'b1;
    step;
    code_valid = 1'b0;
    bit_valid = 1'b1;
    bit_data = 1'b1;
    step;
    step;
    bit_data = 1'b0;
    step;
    bit_valid = 1'b0;
    check("rst_ylin busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("rst_ylin busy", 32'(busy), 32'd0);
    check("rst_ylin out_valid", 32'(out_valid), 32'd0);
    bit_valid = 1'b1;
    step;
    step;
    bit_valid = 1'b0;
    check("rst_ylin no_output", 32'(out_valid), 32'd0);
    run_pair("after_rst", 4'd15, 4'd15, 4'd2, 32'b100011, 6, 17, -16, 1'b0);
    rst = 1'b1;
    code_x = 4'd1;
    code_y = 4'd1;
    linbits = 4'd0;
    code_valid = 1'b1;
    step;
    rst = 1'b0;
    code_valid = 1'b0;
    check("rst_wins busy", 32'(busy), 32'd0);
    step;
    check("rst_wins out_valid", 32'(out_valid), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
